// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the fetch stage and the IF/ID register.
//   fetch_state_t : fetch FSM states (fetch, hold a fetched word, kill a flushed request)
//   NOP_INST      : instruction word used as a pipeline bubble
//   INST_W, REG_ADDR_W, RS_LSB, RT_LSB : instruction width and register-field positions
package cpu_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_LSB     = 16;

    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        StFetch = 2'd0,
        StHold  = 2'd1,
        StKill  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i         : capture {pc4_i, inst_i} as a valid instruction
//   bubble_i       : load a bubble (pc4 0, NOP, invalid); wins over load_i
//   pc4_i, inst_i  : PC+4 and instruction word to capture
//   pc4_o, inst_o, valid_o : register contents
//   rs_o, rt_o     : rs/rt fields of the held instruction
// With neither load_i nor bubble_i the register holds.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  load_i,
    input  logic                  bubble_i,
    input  logic [31:0]           pc4_i,
    input  logic [INST_W-1:0]     inst_i,
    output logic [31:0]           pc4_o,
    output logic [INST_W-1:0]     inst_o,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] rs_o,
    output logic [REG_ADDR_W-1:0] rt_o
);

    logic [31:0]       pc4_q;
    logic [INST_W-1:0] inst_q;
    logic              valid_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc4_q   <= 32'h0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            pc4_q   <= 32'h0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load_i) begin
            pc4_q   <= pc4_i;
            inst_q  <= inst_i;
            valid_q <= 1'b1;
        end
    end

    assign pc4_o   = pc4_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;
    assign rs_o    = inst_q[RS_LSB +: REG_ADDR_W];
    assign rt_o    = inst_q[RT_LSB +: REG_ADDR_W];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage; owns the PC, the imem request handshake and IF/ID.
//   clk_i, rst_n_i             : clock, asynchronous active-low reset
//   pc_write_i, if_id_write_i  : hazard-unit enables; both high = advance
//   flush_i, branch_target_i   : branch taken in ID; bubble IF/ID and redirect the PC
//   imem_req_o, imem_addr_o    : fetch request / word-aligned address (decoded from registers)
//   imem_ack_i, imem_rdata_i   : request complete / instruction word
//   if_id_pc4_o, if_id_inst_o, if_id_valid_o, if_id_rs_o, if_id_rt_o : IF/ID contents
//   stall_cnt_o                : saturating stall-cycle count (only with FETCH_STALL_CNT_EN)
// Optional feature macro: FETCH_STALL_CNT_EN.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   pc_write_i,
    input  logic                   if_id_write_i,
    input  logic                   flush_i,
    input  logic [31:0]            branch_target_i,
    output logic                   imem_req_o,
    output logic [31:0]            imem_addr_o,
    input  logic                   imem_ack_i,
    input  logic [INST_W-1:0]      imem_rdata_i,
`ifdef FETCH_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
`endif
    output logic [31:0]            if_id_pc4_o,
    output logic [INST_W-1:0]      if_id_inst_o,
    output logic                   if_id_valid_o,
    output logic [REG_ADDR_W-1:0]  if_id_rs_o,
    output logic [REG_ADDR_W-1:0]  if_id_rt_o
);

    fetch_state_t      state_q;
    logic [31:0]       pc_q;
    logic [31:0]       redirect_q;
    logic [INST_W-1:0] hold_q;

    logic              advance;
    logic              avail;
    logic [31:0]       pc_plus4;
    logic [31:0]       target_aligned;
    logic              ifid_load;
    logic              ifid_bubble;
    logic [INST_W-1:0] ifid_inst;

    // A mixed pair of enables is treated as a stall.
    assign advance        = pc_write_i & if_id_write_i;
    assign avail          = ((state_q == StFetch) & imem_ack_i) | (state_q == StHold);
    assign pc_plus4       = pc_q + 32'd4;
    assign target_aligned = {branch_target_i[31:2], 2'b00};

    // Request is off in HOLD (word already buffered) and while reset is asserted.
    assign imem_req_o  = rst_n_i & (state_q != StHold);
    assign imem_addr_o = pc_q;

    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_inst   = (state_q == StHold) ? hold_q : imem_rdata_i;
        if (flush_i) begin
            ifid_bubble = 1'b1;
        end else if (advance) begin
            if (avail) ifid_load   = 1'b1;
            else       ifid_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StFetch;
            pc_q       <= {RESET_PC[31:2], 2'b00};
            redirect_q <= 32'h0;
            hold_q     <= NOP_INST;
        end else if (flush_i) begin
            hold_q <= NOP_INST;
            // An un-acked request cannot be withdrawn: park the target until it completes.
            if ((state_q != StHold) && !imem_ack_i) begin
                redirect_q <= target_aligned;
                state_q    <= StKill;
            end else begin
                pc_q    <= target_aligned;
                state_q <= StFetch;
            end
        end else begin
            case (state_q)
                StFetch: begin
                    if (imem_ack_i) begin
                        if (advance) begin
                            pc_q <= pc_plus4;
                        end else begin
                            hold_q  <= imem_rdata_i;
                            state_q <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (advance) begin
                        pc_q    <= pc_plus4;
                        hold_q  <= NOP_INST;
                        state_q <= StFetch;
                    end
                end
                StKill: begin
                    if (imem_ack_i) begin
                        pc_q    <= redirect_q;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StFetch;
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (!advance && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    if_id_reg u_if_id_reg (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (ifid_load),
        .bubble_i (ifid_bubble),
        .pc4_i    (pc_plus4),
        .inst_i   (ifid_inst),
        .pc4_o    (if_id_pc4_o),
        .inst_o   (if_id_inst_o),
        .valid_o  (if_id_valid_o),
        .rs_o     (if_id_rs_o),
        .rt_o     (if_id_rt_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a spec-level model and a
// memory responder with configurable wait states.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic        pc_write_i;
    logic        if_id_write_i;
    logic        flush_i;
    logic [31:0] branch_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_inst_o;
    logic        if_id_valid_o;
    logic [4:0]  if_id_rs_o;
    logic [4:0]  if_id_rt_o;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC    (32'h0000_0000),
        .STALL_CNT_W (16)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n_i),
        .pc_write_i      (pc_write_i),
        .if_id_write_i   (if_id_write_i),
        .flush_i         (flush_i),
        .branch_target_i (branch_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (imem_ack_i),
        .imem_rdata_i    (imem_rdata_i),
`ifdef FETCH_STALL_CNT_EN
        .stall_cnt_o     (stall_cnt_o),
`endif
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_inst_o    (if_id_inst_o),
        .if_id_valid_o   (if_id_valid_o),
        .if_id_rs_o      (if_id_rs_o),
        .if_id_rt_o      (if_id_rt_o)
    );

    int errors = 0;
    int checks = 0;

    // Model: what the pipeline must look like, in the specification's terms.
    logic [31:0] m_pc, m_redirect, m_buf, m_pc4, m_inst;
    bit          m_kill;      // a flushed request is still outstanding
    bit          m_buffered;  // a fetched word waits for the stall to clear
    bit          m_valid;
    int unsigned m_stall;
    int          waits;       // memory wait states
    int          ws;          // cycles the current request has waited

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h8C22_0004;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_redirect = 32'h0; m_buf = 32'h0;
        m_pc4 = 32'h0; m_inst = 32'h0; m_valid = 1'b0;
        m_kill = 1'b0; m_buffered = 1'b0; m_stall = 0; ws = 0;
    endtask

    task automatic compare_all();
        check("req", {31'h0, imem_req_o}, {31'h0, rst_n_i & ~m_buffered});
        check("addr", imem_addr_o, m_pc);
        check("pc4", if_id_pc4_o, m_pc4);
        check("inst", if_id_inst_o, m_inst);
        check("valid", {31'h0, if_id_valid_o}, {31'h0, m_valid});
        check("rs", {27'h0, if_id_rs_o}, {27'h0, m_inst[25:21]});
        check("rt", {27'h0, if_id_rt_o}, {27'h0, m_inst[20:16]});
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt", {16'h0, stall_cnt_o}, (m_stall > 65535) ? 32'hFFFF : m_stall);
`endif
    endtask

    task automatic model_update(input bit adv, input bit fl, input logic [31:0] tgt,
                                input bit ack, input logic [31:0] rdata);
        bit          have;
        bit          was_buffered;
        logic [31:0] word;
        was_buffered = m_buffered;
        have = m_buffered || (!m_kill && ack);
        word = m_buffered ? m_buf : rdata;
        if (!adv && m_stall < 65535) m_stall++;
        if (fl) begin
            m_pc4 = 0; m_inst = 0; m_valid = 0;
            m_buffered = 0;
            if (!was_buffered && !ack) begin
                m_kill = 1; m_redirect = {tgt[31:2], 2'b00};
            end else begin
                m_kill = 0; m_pc = {tgt[31:2], 2'b00};
            end
        end else if (m_kill) begin
            if (ack) begin m_pc = m_redirect; m_kill = 0; end
            if (adv) begin m_pc4 = 0; m_inst = 0; m_valid = 0; end
        end else if (adv) begin
            if (have) begin
                m_pc4 = m_pc + 4; m_inst = word; m_valid = 1;
                m_pc = m_pc + 4; m_buffered = 0;
            end else begin
                m_pc4 = 0; m_inst = 0; m_valid = 0;
            end
        end else if (ack && !m_buffered) begin
            m_buffered = 1; m_buf = rdata;
        end
    endtask

    // One clock cycle: drive inputs and memory response, compare, advance the model.
    task automatic step(input bit pw, input bit iw, input bit fl, input logic [31:0] tgt);
        bit          ack;
        logic [31:0] rdata;
        @(negedge clk);
        ack = 0;
        rdata = $urandom;
        if (!m_buffered) begin
            if (ws >= waits) begin
                ack = 1; rdata = mem_word(m_pc); ws = 0;
            end else begin
                ws++;
            end
        end
        pc_write_i = pw; if_id_write_i = iw; flush_i = fl; branch_target_i = tgt;
        imem_ack_i = ack; imem_rdata_i = rdata;
        #1;
        compare_all();
        model_update(pw & iw, fl, tgt, ack, rdata);
    endtask

    initial begin
        rst_n_i = 0; pc_write_i = 0; if_id_write_i = 0; flush_i = 0;
        branch_target_i = 0; imem_ack_i = 0; imem_rdata_i = 0; waits = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, imem_req_o}, 32'h0);
        check("rst_valid", {31'h0, if_id_valid_o}, 32'h0);
        check("rst_pc4", if_id_pc4_o, 32'h0);
        check("rst_inst", if_id_inst_o, 32'h0);
        @(posedge clk); #1 rst_n_i = 1;

        // Streaming with single-cycle memory.
        step(1, 1, 0, 0);
        check("first_req", {31'h0, imem_req_o}, 32'h1);
        check("first_addr", imem_addr_o, 32'h0);
        step(1, 1, 0, 0);
        check("s2_addr", imem_addr_o, 32'h4);
        check("s2_pc4", if_id_pc4_o, 32'h4);
        check("s2_valid", {31'h0, if_id_valid_o}, 32'h1);
        // Three stall cycles (last one with mixed enables).
        step(0, 0, 0, 0);
        check("s3_inst", if_id_inst_o, 32'h8C22_0004);
        check("s3_addr", imem_addr_o, 32'h8);
        check("s3_rs", {27'h0, if_id_rs_o}, 32'd1);
        check("s3_rt", {27'h0, if_id_rt_o}, 32'd2);
        step(0, 0, 0, 0);
        check("hold_req", {31'h0, imem_req_o}, 32'h0);
        check("hold_pc4", if_id_pc4_o, 32'h8);
        step(1, 0, 0, 0);
        check("hold_inst", if_id_inst_o, 32'h8C22_0004);
        step(1, 1, 0, 0);
        check("release_req", {31'h0, imem_req_o}, 32'h0);
`ifdef FETCH_STALL_CNT_EN
        check("stall3", {16'h0, stall_cnt_o}, 32'd3);
`endif
        // Flush with single-cycle memory; target low bits ignored.
        step(1, 1, 1, 32'h43);
        check("buf_pc4", if_id_pc4_o, 32'hC);
        check("buf_inst", if_id_inst_o, 32'h1357_9BD7);
        step(1, 1, 0, 0);
        check("flush_bubble", {31'h0, if_id_valid_o}, 32'h0);
        check("flush_inst", if_id_inst_o, 32'h0);
        check("flush_addr", imem_addr_o, 32'h40);
        step(1, 1, 0, 0);
        check("after_flush_pc4", if_id_pc4_o, 32'h44);

        // Two wait states, flush in the first wait cycle.
        waits = 2;
        step(1, 1, 1, 32'h100);
        step(1, 1, 0, 0);
        check("kill_addr", imem_addr_o, 32'h48);
        check("kill_valid", {31'h0, if_id_valid_o}, 32'h0);
        step(1, 1, 0, 0);
        check("kill_addr2", imem_addr_o, 32'h48);
        step(1, 1, 0, 0);
        check("redirect_addr", imem_addr_o, 32'h100);
        check("redirect_valid", {31'h0, if_id_valid_o}, 32'h0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h200);
        check("wait_pc4", if_id_pc4_o, 32'h104);
        check("wait_valid", {31'h0, if_id_valid_o}, 32'h1);
        // Second flush during KILL overwrites the redirect.
        step(1, 1, 1, 32'h300);
        step(1, 1, 0, 0);
        waits = 0;
        step(1, 1, 0, 0);
        check("overwrite_addr", imem_addr_o, 32'h300);

        // Flush together with a stall: flush wins.
        step(0, 0, 1, 32'h80);
        check("pre_fs_pc4", if_id_pc4_o, 32'h304);
        step(1, 1, 0, 0);
        check("fs_addr", imem_addr_o, 32'h80);
        check("fs_valid", {31'h0, if_id_valid_o}, 32'h0);

        // Flush while HOLD, then fetch across the wrap.
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'hFFFF_FFFC);
        check("hold_flush_req", {31'h0, imem_req_o}, 32'h0);
        step(1, 1, 0, 0);
        check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        check("wrap_pc4", if_id_pc4_o, 32'h0);
        check("wrap_next_addr", imem_addr_o, 32'h0);
        check("wrap_inst", if_id_inst_o, 32'hECA8_6423);

        // Reset in the middle of a waited transaction.
        waits = 2;
        step(1, 1, 0, 0);
        @(negedge clk);
        rst_n_i = 0;
        #1;
        check("midrst_req", {31'h0, imem_req_o}, 32'h0);
        check("midrst_valid", {31'h0, if_id_valid_o}, 32'h0);
        check("midrst_addr", imem_addr_o, 32'h0);
        model_reset();
        @(posedge clk); #1 rst_n_i = 1;
        waits = 0;
        step(1, 1, 0, 0);
        check("rerun_req", {31'h0, imem_req_o}, 32'h1);
        step(1, 1, 0, 0);
        check("rerun_pc4", if_id_pc4_o, 32'h4);
        step(1, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register, drives the instruction-memory request handshake, and holds the IF/ID pipeline register. It obeys the hazard unit's PC-write/IF/ID-write enables, applies branch flushes from ID, and exports the IF/ID rs/rt fields that the hazard unit compares against ID/EX.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- STALL_CNT_W, 16: stall counter width; used only with FETCH_STALL_CNT_EN.

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- pc_write_i  in  1  from hazard unit; 0 = hold PC
- if_id_write_i  in  1  from hazard unit; 0 = hold IF/ID
- flush_i  in  1  branch taken in ID; kill the IF/ID contents and redirect
- branch_target_i  in  32  redirect PC, sampled when flush_i=1
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, word aligned
- imem_ack_i  in  1  request complete; may be high in the same cycle as imem_req_o
- imem_rdata_i  in  32  instruction; valid only when imem_ack_i=1
- if_id_pc4_o  out  32  PC+4 of the instruction in IF/ID
- if_id_inst_o  out  32  instruction in IF/ID (32'h0 = bubble)
- if_id_valid_o  out  1  IF/ID holds a real instruction
- if_id_rs_o, if_id_rt_o  out  5  if_id_inst_o[25:21], [20:16]
- stall_cnt_o  out  STALL_CNT_W  stall cycle count (FETCH_STALL_CNT_EN only)

## Operation
- advance = pc_write_i & if_id_write_i. HD always drives both the same way; any mixed value counts as a stall.
- Three-state FSM:
  - FETCH: imem_req_o=1, imem_addr_o=PC.
  - HOLD: instruction fetched but the pipeline is stalled; the word sits in an internal buffer; imem_req_o=0.
  - KILL: a flushed request is still outstanding; imem_req_o=1 and imem_addr_o keeps the old PC.
- Instruction available (avail) = (FETCH & imem_ack_i) | HOLD.
- Priority each cycle: reset > flush > stall > normal.
- flush_i=1, in any state and regardless of the stall inputs:
  - IF/ID loads a bubble: inst 0, valid 0, pc4 0.
  - Any HOLD buffer is dropped.
  - If in FETCH or KILL without imem_ack_i: the target goes into the redirect register and the FSM goes to KILL.
  - Otherwise PC <= branch_target_i and the FSM goes to FETCH.
- KILL with imem_ack_i: rdata is discarded, PC <= redirect register, next state FETCH. A second flush while in KILL overwrites the redirect register.
- No flush, advance=1:
  - If avail: IF/ID <= {PC+4, word, valid 1}, PC <= PC+4, next state FETCH.
  - Else: IF/ID <= bubble and the FSM stays in FETCH.
- No flush, advance=0: IF/ID and PC hold. FETCH with ack moves to HOLD, capturing imem_rdata_i. HOLD stays in HOLD.
- PC+4 wraps modulo 2^32. PC[1:0] is always 0; branch_target_i[1:0] is ignored.

## Timing
- Reset values:
  - PC = RESET_PC; FSM = FETCH; redirect = 0; HOLD buffer = 0.
  - if_id_pc4_o = 0, if_id_inst_o = 0, if_id_valid_o = 0, stall_cnt_o = 0.
  - imem_req_o = 0 while rst_n_i is low.
- imem_req_o is 1 in the first cycle after reset release.
- Single-cycle memory (ack with req) gives 1 instruction per cycle. Fetch-to-IF/ID latency is 1 edge after ack.
- imem_req_o and imem_addr_o are decoded from registers only. They do not depend combinationally on imem_ack_i, flush_i or the stall inputs.
- All outputs except imem_req_o and imem_addr_o are registered.
- The IF/ID rs/rt fields are valid one cycle after IF/ID loads, ready for HD in that same cycle.
- Reset asserted mid-transaction aborts it. Any ack arriving after reset release for a pre-reset request is the memory's responsibility to suppress.

## Configuration
- FETCH_STALL_CNT_EN:
  - Defined: stall_cnt_o exists and increments on each cycle with advance=0 & rst_n_i=1. It saturates at all-ones and ignores flush.
  - Undefined: the port and the counter are absent.

## Structure
- Shared package cpu_pkg:
  - fetch_state_t enum (FETCH, HOLD, KILL)
  - NOP_INST = 32'h0
  - INST_W = 32, REG_ADDR_W = 5
  - RS/RT field bit positions
- Sub-module if_id_reg: IF/ID register with load, bubble and hold controls. The FSM and PC stay in fetch_stage.

## Test plan
- Reset release, RESET_PC=0, ack tied to req, advance=1 → addresses 0,4,8 on consecutive cycles; if_id_pc4_o = 4,8,12; valid=1 from the 2nd edge.
- HD stall for 3 cycles while IF/ID holds 0x8C220004 → PC and IF/ID unchanged, imem_req_o drops after one ack (HOLD), stall_cnt_o +3 when enabled. On release, the buffered word enters IF/ID with no new request.
- flush_i with branch_target_i=0x40, single-cycle memory → IF/ID is a bubble next cycle and the next imem_addr_o = 0x40.
- Memory with 2 wait states, flush in the first wait cycle with target 0x100 → addr stays 0x08 until ack; that data is discarded; next request is 0x100; no valid=1 instruction from 0x08.
- flush and HD stall asserted together → flush wins: bubble loaded, PC redirected.
- PC=0xFFFF_FFFC fetched with advance → if_id_pc4_o = 0, next address 0.
